lfsr_period_monitor: RTL and testbench

//  Downstream checker for the reconfigurable LFSR. It samples the LFSR state on

---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/lfsr_period_monitor.sv | 138 +++++++++++++
 tb/tb_lfsr_period_monitor.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR self-test logic: monitor FSM encoding and
// period helpers.
package lfsr_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ARM   = ST_ARM,
        COUNT = ST_COUNT,
        DONE  = ST_DONE
    } mon_state_e;

    // Period of a maximal-length LFSR of the given width.
    function automatic int unsigned max_period(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_period_monitor.sv
// Measures the period of the sampled LFSR sequence and flags lockup, tail
// sequences (timeout) and maximal-length operation.
module lfsr_period_monitor
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] lfsr_state,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   period,
    output logic             maximal,
    output logic             lockup,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] ZERO_STATE = {WIDTH{1'b0}};
    localparam logic [WIDTH:0]   CNT_ZERO   = {(WIDTH+1){1'b0}};
    localparam logic [WIDTH:0]   CNT_ONE    = (WIDTH+1)'(32'd1);
    localparam logic [WIDTH:0]   CNT_MAX    = {(WIDTH+1){1'b1}};
    localparam logic [WIDTH:0]   MAX_PERIOD = (WIDTH+1)'(max_period(WIDTH));
    localparam logic [WIDTH:0]   FULL_COUNT = (WIDTH+1)'(32'd1 << WIDTH);

    mon_state_e       state_r;
    logic [WIDTH-1:0] ref_r;
    logic [WIDTH:0]   cnt_r;
    logic [WIDTH:0]   cnt_inc_s;
    logic             is_zero_s;
    logic             is_ref_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH:0]   period_r;
    logic             maximal_r;
    logic             lockup_r;
    logic             timeout_r;

    // Saturating step count and sample classification for the COUNT state.
    always_comb begin
        cnt_inc_s = cnt_r;
        if (cnt_r != CNT_MAX) begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end else begin
            cnt_inc_s = cnt_r;
        end
        is_zero_s = (lfsr_state == ZERO_STATE);
        is_ref_s  = (lfsr_state == ref_r);
    end

    // Measurement FSM with registered result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            ref_r     <= ZERO_STATE;
            cnt_r     <= CNT_ZERO;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            period_r  <= CNT_ZERO;
            maximal_r <= 1'b0;
            lockup_r  <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            // A start request in any state (re)arms and clears the previous results.
            if (start) begin
                state_r   <= ARM;
                busy_r    <= 1'b1;
                period_r  <= CNT_ZERO;
                maximal_r <= 1'b0;
                lockup_r  <= 1'b0;
                timeout_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    ARM: begin
                        if (sample_valid) begin
                            if (is_zero_s) begin
                                state_r  <= DONE;
                                busy_r   <= 1'b0;
                                done_r   <= 1'b1;
                                lockup_r <= 1'b1;
                            end else begin
                                ref_r   <= lfsr_state;
                                cnt_r   <= CNT_ZERO;
                                state_r <= COUNT;
                            end
                        end
                    end
                    COUNT: begin
                        if (sample_valid) begin
                            cnt_r <= cnt_inc_s;
                            if (is_zero_s) begin
                                state_r  <= DONE;
                                busy_r   <= 1'b0;
                                done_r   <= 1'b1;
                                lockup_r <= 1'b1;
                                period_r <= CNT_ZERO;
                            end else if (is_ref_s) begin
                                state_r   <= DONE;
                                busy_r    <= 1'b0;
                                done_r    <= 1'b1;
                                period_r  <= cnt_inc_s;
                                maximal_r <= (cnt_inc_s == MAX_PERIOD);
                            end else if (cnt_inc_s == FULL_COUNT) begin
                                state_r   <= DONE;
                                busy_r    <= 1'b0;
                                done_r    <= 1'b1;
                                timeout_r <= 1'b1;
                                period_r  <= CNT_ZERO;
                            end
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign period  = period_r;
    assign maximal = maximal_r;
    assign lockup  = lockup_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Randomized self-checking bench for lfsr_period_monitor (WIDTH=3) against a
// sequence-level reference model.
module tb_lfsr_period_monitor;

    localparam int W = 3;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         sample_valid;
    logic [W-1:0] lfsr_state;
    logic         busy;
    logic         done;
    logic [W:0]   period;
    logic         maximal;
    logic         lockup;
    logic         timeout;

    int n_checks;
    int n_pass;

    logic [W-1:0] seq [0:8];

    lfsr_period_monitor #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .sample_valid (sample_valid),
        .lfsr_state   (lfsr_state),
        .busy         (busy),
        .done         (done),
        .period       (period),
        .maximal      (maximal),
        .lockup       (lockup),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s, input logic [W-1:0] taps);
        return {s[W-2:0], ^(s & taps)};
    endfunction

    // mode 0: Fibonacci LFSR from first; mode 1: arbitrary random values.
    task automatic build_seq(input int mode, input logic [W-1:0] taps, input logic [W-1:0] first);
        seq[0] = first;
        for (int i = 1; i < 9; i++) begin
            if (mode == 0) seq[i] = lfsr_next(seq[i-1], taps);
            else           seq[i] = W'($urandom_range(7));
        end
    endtask

    // Index of the terminating sample plus the expected results.
    task automatic model(output int t, output int per, output bit lock, output bit tmo);
        t = -1; per = 0; lock = 1'b0; tmo = 1'b0;
        if (seq[0] == '0) begin
            t = 0; lock = 1'b1;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                if (t < 0) begin
                    if (seq[k] == '0)          begin t = k; lock = 1'b1; end
                    else if (seq[k] == seq[0]) begin t = k; per = k; end
                    else if (k == 8)           begin t = k; tmo = 1'b1; end
                end
            end
        end
    endtask

    task automatic run(input int mode, input logic [W-1:0] taps, input logic [W-1:0] seed,
                       input int vpct, input int abort_after, input bit chain);
        int  idx, t, per, cyc;
        bit  lock, tmo, aborted, finished;
        build_seq(mode, taps, seed);
        model(t, per, lock, tmo);
        @(negedge clk);
        start = 1'b1; sample_valid = 1'b0; lfsr_state = seq[0];
        @(negedge clk);
        start = 1'b0;
        check_eq("arm_busy", 32'(busy), 32'd1);
        check_eq("arm_period_clr", 32'(period), 32'd0);
        check_eq("arm_flags_clr", {29'd0, maximal, lockup, timeout}, 32'd0);
        idx = 0; finished = 1'b0; cyc = 0; aborted = (abort_after < 0);
        while (!finished && cyc < 200) begin
            cyc++;
            if (!aborted && idx == abort_after) begin
                start = 1'b1; sample_valid = 1'b1; lfsr_state = seq[idx];
                @(negedge clk);
                start = 1'b0; aborted = 1'b1;
                check_eq("abort_no_done", 32'(done), 32'd0);
                check_eq("abort_busy", 32'(busy), 32'd1);
                build_seq(mode, taps, seq[idx]);
                idx = 0;
                model(t, per, lock, tmo);
            end else begin
                sample_valid = ($urandom_range(99) < 32'(vpct));
                lfsr_state = sample_valid ? seq[idx] : W'($urandom);
                @(negedge clk);
                if (sample_valid && idx == t) begin
                    finished = 1'b1;
                    check_eq("done", 32'(done), 32'd1);
                    check_eq("done_busy", 32'(busy), 32'd0);
                    check_eq("period", 32'(period), 32'(per));
                    check_eq("lockup", 32'(lockup), 32'(lock));
                    check_eq("timeout", 32'(timeout), 32'(tmo));
                    check_eq("maximal", 32'(maximal), (per == 7) ? 32'd1 : 32'd0);
                end else begin
                    if (sample_valid) idx++;
                    check_eq("no_early_done", 32'(done), 32'd0);
                end
            end
        end
        sample_valid = 1'b0;
        if (!finished) check_eq("done_within_budget", 32'd0, 32'd1);
        if (chain) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_eq("restart_from_done_busy", 32'(busy), 32'd1);
            check_eq("restart_from_done_period", 32'(period), 32'd0);
            check_eq("restart_from_done_no_done", 32'(done), 32'd0);
        end else begin
            @(negedge clk);
            check_eq("idle_done_low", 32'(done), 32'd0);
            check_eq("idle_busy_low", 32'(busy), 32'd0);
            check_eq("idle_period_hold", 32'(period), 32'(per));
        end
    endtask

    initial begin
        logic [W-1:0] s;
        n_checks = 0; n_pass = 0;
        reset_n = 1'b0; start = 1'b0; sample_valid = 1'b0; lfsr_state = '0;
        #12;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_period", 32'(period), 32'd0);
        check_eq("reset_flags", {29'd0, maximal, lockup, timeout}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run(0, 3'b110, 3'b001, 100, -1, 1'b0);
        run(0, 3'b100, 3'b001, 100, -1, 1'b0);
        run(0, 3'b000, 3'b001, 100, -1, 1'b0);
        run(0, 3'b011, 3'b001, 100, -1, 1'b0);
        run(0, 3'b110, 3'b001, 50, -1, 1'b0);
        run(0, 3'b110, 3'b001, 100, 3, 1'b0);
        run(0, 3'b110, 3'b001, 100, -1, 1'b1);
        run(0, 3'b100, 3'b001, 100, -1, 1'b0);

        // Asynchronous reset in the middle of a measurement.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; sample_valid = 1'b1; s = 3'b001;
        repeat (3) begin
            lfsr_state = s;
            @(negedge clk);
            s = lfsr_next(s, 3'b110);
        end
        check_eq("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_reset_busy", 32'(busy), 32'd0);
        check_eq("async_reset_done", 32'(done), 32'd0);
        check_eq("async_reset_period", 32'(period), 32'd0);
        check_eq("async_reset_flags", {29'd0, maximal, lockup, timeout}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1; sample_valid = 1'b0;
        run(0, 3'b110, 3'b001, 100, -1, 1'b0);

        for (int r = 0; r < 30; r++) begin
            run(int'($urandom_range(1)), W'($urandom), W'($urandom),
                int'($urandom_range(100, 30)),
                ($urandom_range(3) == 0) ? int'($urandom_range(5)) : -1,
                1'($urandom_range(1)));
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
